// File: rtl/matrix_result_packer_pkg.sv
// Shared types and constants for the matrix result packer: result/line widths,
// the controller state enum, the line type and the optional ReLU helper.
package matrix_result_packer_pkg;

  localparam int RESULT_W = 32;
  localparam int LINE_W   = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [LINE_W-1:0] line_t;

  function automatic logic [RESULT_W-1:0] relu(input logic [RESULT_W-1:0] v);
    return v[RESULT_W-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/matrix_result_packer_result_line_fifo.sv
// Synchronous line FIFO, LINE_W wide and DEPTH deep (DEPTH a power of two).
// A push while full is accepted when a pop happens on the same edge.
module result_line_fifo
  import matrix_result_packer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  logic  push,
  input  line_t push_line,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output line_t head
);

  localparam int PW = $clog2(DEPTH);

  line_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   used;
  logic          do_push;
  logic          do_pop;

  assign empty   = (used == '0);
  assign full    = (used == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end

  // Storage carries no reset; contents are only visible through head when non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_line;
  end

endmodule

// File: rtl/matrix_result_packer.sv
// Packs 16 PE results per 512-bit line and writes lines to RAM with auto-incrementing
// addresses. Optional macro MATRIX_RESULT_RELU_EN clamps negative results to zero.
module matrix_result_packer
  import matrix_result_packer_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [15:0]       cfg_lines,
  input  logic              flush,
  input  logic [31:0]       pe_result,
  input  logic              pe_vld,
  output logic [511:0]      out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output state_t            dbg_state
);

  localparam int RESULTS_PER_LINE = LINE_W / RESULT_W;
  localparam logic [3:0] LAST_SLOT = 4'(RESULTS_PER_LINE - 1);

  state_t              state;
  state_t              state_next;
  logic [3:0]          count;
  line_t               line_q;
  line_t               packed_line;
  logic [15:0]         lines_written;
  logic [15:0]         cfg_lines_q;
  logic [ADDR_W-1:0]   base_q;
  logic                overflow_q;
  logic [RESULT_W-1:0] pe_in;
  logic                accept_start;
  logic                line_done;
  logic                push_req;
  line_t               push_line;
  logic                fifo_full;
  logic                fifo_empty;
  line_t               fifo_head;
  logic                fifo_pop;
  logic                last_pop;
  logic                push_drop;

`ifdef MATRIX_RESULT_RELU_EN
  assign pe_in = relu(pe_result);
`else
  assign pe_in = pe_result;
`endif

  // out_valid/out_ready: a line transfers on every edge where both are high;
  // out_valid never depends on out_ready, and the line/address hold until taken.
  assign fifo_pop     = !fifo_empty && out_ready;
  assign accept_start = (state == IDLE) && start;
  assign line_done    = (state == RUN) && pe_vld && (count == LAST_SLOT);
  assign last_pop     = fifo_pop && ((state == RUN) || (state == FLUSH)) &&
                        ((lines_written + 16'd1) == cfg_lines_q);

  always_comb begin
    packed_line = line_q;
    packed_line[RESULT_W*count +: RESULT_W] = pe_in;
  end

  always_comb begin
    push_req  = 1'b0;
    push_line = packed_line;
    if (line_done) begin
      push_req = 1'b1;
    end else if (state == FLUSH) begin
      push_req  = 1'b1;
      push_line = line_q;
    end
  end

  assign push_drop = push_req && fifo_full && !fifo_pop;

  result_line_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept_start),
    .push      (push_req),
    .push_line (push_line),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (cfg_lines == 16'd0) ? DONE : RUN;
      RUN: begin
        if (last_pop) state_next = DONE;
        else if (flush && (count != 4'd0) && !line_done) state_next = FLUSH;
      end
      FLUSH: state_next = last_pop ? DONE : RUN;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      line_q        <= '0;
      lines_written <= '0;
      cfg_lines_q   <= '0;
      base_q        <= '0;
      overflow_q    <= 1'b0;
    end else if (accept_start) begin
      count         <= '0;
      line_q        <= '0;
      lines_written <= '0;
      cfg_lines_q   <= cfg_lines;
      base_q        <= cfg_base_addr;
      overflow_q    <= 1'b0;
    end else begin
      if (fifo_pop) lines_written <= lines_written + 16'd1;
      if (state == RUN && pe_vld) begin
        // Slots beyond count stay zero, so a flushed line is already padded.
        if (line_done) begin
          line_q <= '0;
          count  <= '0;
        end else begin
          line_q <= packed_line;
          count  <= count + 4'd1;
        end
      end
      if (state == FLUSH) begin
        line_q <= '0;
        count  <= '0;
      end
      if (push_drop || (state == FLUSH && pe_vld)) overflow_q <= 1'b1;
    end
  end

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_head;
  assign out_addr  = base_q + lines_written[ADDR_W-1:0];
  assign overflow  = overflow_q;

endmodule
